// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8:1 mux-tree round-robin arbiter.
package mux8_rr_arbiter_pkg;

  localparam int NREQ         = 8;
  localparam int SELW         = 3;
  localparam int HOLD_MAX_DEF = 4;
  localparam int HOLDW        = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [SELW-1:0] SRC_A1 = 3'd0;
  localparam logic [SELW-1:0] SRC_A2 = 3'd1;
  localparam logic [SELW-1:0] SRC_B1 = 3'd2;
  localparam logic [SELW-1:0] SRC_B2 = 3'd3;
  localparam logic [SELW-1:0] SRC_C1 = 3'd4;
  localparam logic [SELW-1:0] SRC_C2 = 3'd5;
  localparam logic [SELW-1:0] SRC_D1 = 3'd6;
  localparam logic [SELW-1:0] SRC_D2 = 3'd7;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first unmasked request at or after ptr, wrapping 7->0.
module rr_pick
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic [NREQ-1:0] mask,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [NREQ-1:0] cand;
  logic [SELW-1:0] j;

  assign cand = req & ~mask;

  // Scan from the farthest offset down so the nearest hit to ptr is kept last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      j = ptr + SELW'(i);
      if (cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner FSM, hold timer and registered data path for the 8:1 mux tree.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] data_in,
  output logic [NREQ-1:0] grant,
  output logic            sel_pair,
  output logic            sel_quad,
  output logic            sel_half,
  output logic            y,
  output logic            y_valid
);

  // state | meaning
  // IDLE  | no owner, grant=0, sel holds last owner index
  // GRANT | sel is the owner, grant one-hot on it

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_MAX - 1);

  state_t          state, state_next;
  logic [SELW-1:0] sel, sel_next;
  logic [SELW-1:0] ptr, ptr_next;
  logic [HOLDW-1:0] cnt, cnt_next;
  logic [NREQ-1:0] mask;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic            owner_req;

  assign mask      = (state == ST_GRANT) ? (NREQ'(1) << sel) : '0;
  assign owner_req = req[sel];

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state;
    sel_next   = sel;
    ptr_next   = ptr;
    cnt_next   = cnt;
    if (state == ST_IDLE) begin
      if (pick_found) begin
        state_next = ST_GRANT;
        sel_next   = pick_idx;
        ptr_next   = pick_idx + 1'b1;
        cnt_next   = '0;
      end
    end else if (!owner_req || (pick_found && cnt >= HOLD_LAST)) begin
      // Release or hold expiry: hand over on this edge when anyone else waits.
      if (pick_found) begin
        sel_next = pick_idx;
        ptr_next = pick_idx + 1'b1;
        cnt_next = '0;
      end else begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end else if (!pick_found) begin
      cnt_next = (cnt >= HOLD_LAST) ? HOLD_LAST : cnt + 1'b1;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_next;
      sel     <= sel_next;
      ptr     <= ptr_next;
      cnt     <= cnt_next;
      grant   <= (state_next == ST_GRANT) ? (NREQ'(1) << sel_next) : '0;
      y       <= data_in[sel_next];
      y_valid <= (state_next == ST_GRANT);
    end
  end

  assign sel_pair = sel[0];
  assign sel_quad = sel[1];
  assign sel_half = sel[2];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter against a behavioural owner/pointer model.
module tb_mux8_rr_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] data_in = '0;
  logic [7:0] grant;
  logic       sel_pair, sel_quad, sel_half, y, y_valid;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;
  int m_y;

  mux8_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .sel_pair (sel_pair),
    .sel_quad (sel_quad),
    .sel_half (sel_half),
    .y        (y),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
    m_y     = 0;
  endtask

  function automatic int search(input logic [7:0] r, input int from, input int skip);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (from + k) % 8;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % 8;
    m_cnt   = 0;
    m_sel   = w;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic [7:0] d);
    int other;
    other = search(r, m_ptr, m_owner);
    if (m_owner < 0) begin
      if (other >= 0) give(other);
    end else if (!r[m_owner]) begin
      if (other >= 0) give(other);
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else if (other >= 0 && m_cnt == HM - 1) begin
      give(other);
    end else if (other < 0) begin
      m_cnt = (m_cnt + 1 > HM - 1) ? HM - 1 : m_cnt + 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_y = d[m_sel];
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".sel"}, 32'({sel_half, sel_quad, sel_pair}), 32'(m_sel));
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(m_owner >= 0));
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] d);
    req     = r;
    data_in = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.y", 32'(y), 32'd0);
    chk("rst.y_valid", 32'(y_valid), 32'd0);
    chk("rst.sel", 32'({sel_half, sel_quad, sel_pair}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int first_owner;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 5; i++) step("idle", 8'h00, 8'($urandom));

    step("c2", 8'h20, 8'h20);
    chk("c2.grant_const", 32'(grant), 32'h20);
    step("c2_drop", 8'h00, 8'h20);

    do_reset();
    for (int i = 0; i < 36; i++) step("allreq", 8'hFF, 8'($urandom));
    chk("allreq.final_owner", 32'(grant), 32'h01);

    do_reset();
    step("b2_take", 8'h08, 8'h00);
    step("b2_d1_wait", 8'h48, 8'h40);
    step("b2_drop", 8'h40, 8'h40);
    chk("b2_drop.handover", 32'(grant), 32'h40);
    for (int i = 0; i < 10; i++) step("d1_hold", 8'h40, 8'($urandom));
    chk("d1_hold.keep", 32'(grant), 32'h40);

    do_reset();
    for (int i = 0; i < 12; i++) step("a1d2", 8'h81, 8'($urandom));

    step("pre_rst", 8'h10, 8'hFF);
    req = 8'h10;
    #2;
    do_reset();
    step("post_rst", 8'h04, 8'h04);
    chk("post_rst.grant_const", 32'(grant), 32'h04);

    // randomized traffic: sticky requests with sparse toggles, occasional bursts
    first_owner = 0;
    r = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       r = 8'($urandom);
        1:       r = 8'h00;
        2:       r = 8'd1 << $urandom_range(0, 7);
        default: r = r ^ ((8'd1 << $urandom_range(0, 7)) & 8'($urandom));
      endcase
      step("rand", r, 8'($urandom));
      if (i == 1500) begin
        do_reset();
        first_owner++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and select sequencer for the shared 8:1 single-bit mux tree built from 2:1 stages. Eight requesters compete for the output. The block grants one requester at a time and drives the three stage selects (pair / quad / half). It also registers the selected data bit with a valid flag. Grants are held while the owner keeps requesting, and are bounded by HOLD_MAX when others are waiting.

Parameters:
NREQ, 8, number of requesters; fixed to 8 by the mux tree shape.
SELW, 3, select width, log2(NREQ).
HOLD_MAX, 4, max consecutive grant cycles for one owner while another request is pending; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  8  request per source, bit i = source i (order a1,a2,b1,b2,c1,c2,d1,d2 = 0..7).
data_in  input  8  data bit per source, same index order.
grant  output  8  one-hot grant to current owner, all-zero when idle.
sel_pair  output  1  pair-level select (sel[0]); 0 = even index, 1 = odd.
sel_quad  output  1  quad-level select (sel[1]).
sel_half  output  1  top-level select (sel[2]); 0 = sources 0..3, 1 = 4..7.
y  output  1  registered selected data bit.
y_valid  output  1  high when y carries a granted source's data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: grant=0, sel=3'b000, y=0, y_valid=0, state=IDLE, rr pointer ptr=0, hold count=0.
- sel = {sel_half, sel_quad, sel_pair} = binary index of owner. All three are registered with grant, so they change on the same edge.
- The rr pick is a rotating priority search over req, starting at ptr and wrapping 7->0. ptr is set to (winner+1) mod 8 on every new grant.
- States: IDLE and GRANT.
- IDLE, req==0: stay in IDLE. grant=0, and sel holds its last value (no toggling).
- IDLE, req!=0: at the next edge enter GRANT. grant is one-hot on the picked source, sel = its index, hold count=0.
- GRANT, req[owner]==0: release the owner.
  - If any other request is pending, hand over on the same edge to the next pick starting at ptr. There is no idle bubble.
  - Otherwise go to IDLE and grant=0.
- GRANT, req[owner]==1, hold count==HOLD_MAX-1, another req pending: rotate to the next pick from ptr, hold count=0.
- GRANT, req[owner]==1, no other req pending: keep the grant. hold count saturates at HOLD_MAX-1.
- Otherwise in GRANT, hold count increments each cycle.
- Data path: every edge, y <= data_in[sel_next] and y_valid <= (state_next==GRANT), where sel_next and state_next are the values being loaded on that edge.
- Latency:
  - req rises at edge t: grant and sel valid after edge t+1.
  - y/y_valid valid after edge t+1, reflecting data_in sampled at edge t+1 for the new owner.
- A requester must not be granted unless its req bit was high at the deciding edge. Simultaneous requests are resolved purely by ptr order.
- Reset asserted mid-grant clears all outputs immediately (asynchronous). After deassertion the first grant starts its search from index 0.
- grant is always zero or one-hot, and sel always equals the index of the set grant bit while in GRANT.

Decomposition:
- Shared package/header holds: NREQ, SELW, HOLD_MAX default, state encodings (IDLE=1'b0, GRANT=1'b1), and the source index constants (SRC_A1=0 .. SRC_D2=7).
- One sub-module, rr_pick: combinational rotating priority encoder. Inputs req[7:0], ptr[2:0], and a mask input that excludes the owner. Outputs found and idx[2:0].
- The FSM, hold counter, pointer and data registers live in mux8_rr_arbiter.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, sel=000, y_valid=0 throughout.
- req=8'h20 (c2) with data_in[5]=1 -> after 1 edge: grant=8'h20, sel=101, y=1, y_valid=1; drop req -> next edge grant=0, y_valid=0.
- req=8'hFF held, HOLD_MAX=4 -> owners 0,1,2,...,7,0 in order, each granted exactly 4 cycles, with no bubble between owners.
- Owner 3 drops req while req[6]=1 and ptr=4 -> next edge grant=8'h40, sel=110, no IDLE cycle; then req[6] alone held 10 cycles -> grant stays 8'h40.
- req=8'h81 from reset -> source 0 wins first (ptr=0); hold expiry -> source 7 granted next; then ptr=0 so source 0 follows.
- rst_n pulsed low mid-grant -> grant, y, and y_valid go to 0 before the next clock edge; after release with req=8'h04, grant=8'h04 after one edge.
